serial_full_adder: RTL and testbench



---
 rtl/serial_full_adder_if.sv | 45 ++++
 rtl/serial_full_adder.sv | 137 +++++++++++++
 tb/tb_serial_full_adder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_full_adder_if.sv
// rtl/serial_full_adder_if.sv - start/done handshake and operand/result bundle for serial_full_adder
//
// Purpose: groups the operand load request and the parallel result of the
// bit-serial adder into one port.
// Ports (signals):
//   start      requester -> adder  load request, honoured only when idle
//   a, b       requester -> adder  WIDTH-bit operands, sampled on accepted start
//   carry_in   requester -> adder  initial carry, sampled on accepted start
//   busy       adder -> requester  high while bits are being added
//   done       adder -> requester  one-cycle pulse when the result becomes valid
//   sum        adder -> requester  WIDTH-bit result, held until the next result
//   carry_out  adder -> requester  final carry, held with sum
//   overflow   adder -> requester  signed overflow (only with SERIAL_FULL_ADDER_OVF_EN)
// Optional feature macro: SERIAL_FULL_ADDER_OVF_EN.
interface serial_full_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b, carry_in,
`ifdef SERIAL_FULL_ADDER_OVF_EN
    input  overflow,
`endif
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
`ifdef SERIAL_FULL_ADDER_OVF_EN
    output overflow,
`endif
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_full_adder.sv
// rtl/serial_full_adder.sv - bit-serial WIDTH-bit adder with start/done handshake
//
// Purpose: loads a, b and carry_in in parallel, adds one bit per clock LSB
// first through a single full-adder cell and a carry flop, then presents the
// parallel sum and carry-out.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high, priority over everything else
//   bus   serial_full_adder_if.slave (start, a, b, carry_in, busy, done,
//         sum, carry_out, and overflow when SERIAL_FULL_ADDER_OVF_EN is defined)
// Parameters: WIDTH operand width (2..32), CW bit-counter width (2^CW > WIDTH).
// Optional feature macro: SERIAL_FULL_ADDER_OVF_EN adds the signed overflow output.
module serial_full_adder #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input logic                clk,
  input logic                rst,
  serial_full_adder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,    sum_sh_d;
  logic             c_q,         c_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             carry_out_q, carry_out_d;
  logic             done_q,      done_d;
  logic             bit_s;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic             ovf_sh_q,    ovf_sh_d;
  logic             overflow_q,  overflow_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;
    bit_s       = 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    ovf_sh_d    = ovf_sh_q;
    overflow_d  = overflow_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.carry_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        c_d      = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
`ifdef SERIAL_FULL_ADDER_OVF_EN
          // On the MSB cycle c_q is the carry into the MSB, c_d the carry out.
          ovf_sh_d = c_q ^ c_d;
`endif
        end
      end
      S_DONE: begin
        // Outputs are only ever loaded here, so partial sums never show.
        sum_d       = sum_sh_q;
        carry_out_d = c_q;
        done_d      = 1'b1;
`ifdef SERIAL_FULL_ADDER_OVF_EN
        overflow_d  = ovf_sh_q;
`endif
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
      ovf_sh_q    <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      done_q      <= done_d;
`ifdef SERIAL_FULL_ADDER_OVF_EN
      ovf_sh_q    <= ovf_sh_d;
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  assign bus.overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// tb/tb_serial_full_adder.sv - directed self-checking bench for serial_full_adder (WIDTH=8)
module tb_serial_full_adder;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] prev_sum;
  logic       prev_cout;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic       prev_ovf;
`endif

  serial_full_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_full_adder #(.WIDTH(WIDTH), .CW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issues one operation, then checks latency, busy length, output stability
  // during the run, the result and the single-cycle done pulse.
  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    int bcnt;
    bit seen;
    bit stable;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = ta;
    bus.b = tb_v;
    bus.carry_in = tc;
    lat = 0; bcnt = 0; seen = 0; stable = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        bus.a = ~ta;
        bus.b = ~tb_v;
        bus.carry_in = ~tc;
      end
      if (bus.done) begin
        seen = 1;
        lat = n;
        break;
      end
      if (bus.busy) bcnt++;
      if (bus.sum !== prev_sum || bus.carry_out !== prev_cout) stable = 0;
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(WIDTH + 2));
    chk({nm, " busy_cycles"}, 32'(bcnt), 32'(WIDTH));
    chk({nm, " outputs_held"}, 32'(stable), 32'd1);
    chk({nm, " sum"}, 32'(bus.sum), 32'(es));
    chk({nm, " carry_out"}, 32'(bus.carry_out), 32'(ec));
`ifdef SERIAL_FULL_ADDER_OVF_EN
    chk({nm, " overflow"}, 32'(bus.overflow), 32'(eo));
    prev_ovf = eo;
`endif
    $display("op %s: sum=%h cout=%0b (signed overflow reference %0b)", nm, bus.sum, bus.carry_out, eo);
    @(negedge clk);
    chk({nm, " done_one_cycle"}, 32'(bus.done), 32'd0);
    prev_sum = es;
    prev_cout = ec;
  endtask

  vec_t vecs[8];

  initial begin
    int dcnt;
    int n1;
    int n2;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    // Reset then idle
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.carry_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle busy", 32'(bus.busy), 32'd0);
      chk("idle done", 32'(bus.done), 32'd0);
      chk("idle sum", 32'(bus.sum), 32'd0);
      chk("idle carry_out", 32'(bus.carry_out), 32'd0);
`ifdef SERIAL_FULL_ADDER_OVF_EN
      chk("idle overflow", 32'(bus.overflow), 32'd0);
`endif
    end
    prev_sum = 8'h00;
    prev_cout = 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    prev_ovf = 1'b0;
`endif

    // Table-driven additions
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // Start during busy: second request must be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.carry_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop busy_at_second_start", 32'(bus.busy), 32'd1);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("drop done_count", 32'(dcnt), 32'd1);
    chk("drop sum", 32'(bus.sum), 32'h30);
    chk("drop busy_after", 32'(bus.busy), 32'd0);
    prev_sum = 8'h30;
    prev_cout = 1'b0;

    // Reset on the 4th RUN cycle
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.carry_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort busy_before", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort sum", 32'(bus.sum), 32'd0);
    chk("abort carry_out", 32'(bus.carry_out), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("abort no_activity", 32'(dcnt), 32'd0);
    prev_sum = 8'h00;
    prev_cout = 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    prev_ovf = 1'b0;
`endif
    run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80; bus.carry_in = 1'b0;
    n1 = 0; n2 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        if (n1 == 0) begin
          n1 = n;
          chk("b2b first sum", 32'(bus.sum), 32'h00);
          chk("b2b first carry_out", 32'(bus.carry_out), 32'd1);
          bus.a = 8'h01; bus.b = 8'h01;
        end else begin
          n2 = n;
          chk("b2b second sum", 32'(bus.sum), 32'h02);
          chk("b2b second carry_out", 32'(bus.carry_out), 32'd0);
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b first latency", 32'(n1), 32'(WIDTH + 2));
    chk("b2b spacing", 32'(n2 - n1), 32'(WIDTH + 2));
    repeat (3) @(negedge clk);
    chk("b2b idle_after", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
